// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT receive-side period meter:
// FSM encoding and default sizing constants.
package swipt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int          DEF_PERIOD_W   = 16;
    localparam int          DEF_AVG_LG     = 3;
    localparam int          DEF_GLITCH_CYC = 2;
    localparam int unsigned DEF_TIMEOUT    = 32'h0000_FFF0;

    // Reference clock, kept here so period_avg can later be turned into Hz.
    localparam int unsigned CLK_HZ = 100_000_000;

endpackage

// File: rtl/swipt_period_meter_if.sv
// Signal bundle between the period meter and its surroundings:
// gating/comparator inputs and the averaged period/status outputs.
interface swipt_period_meter_if #(
    parameter int PERIOD_W = 16
);
    logic                swiptAlive;
    logic                ADC_comp;
    logic [PERIOD_W-1:0] period_avg;
    logic                period_valid;
    logic                locked;
    logic                timeout;

    modport master (
        output swiptAlive,
        output ADC_comp,
        input  period_avg,
        input  period_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  swiptAlive,
        input  ADC_comp,
        output period_avg,
        output period_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/swipt_sync_filter.sv
// Two-flop synchronizer, glitch filter and rising-edge detector for the
// asynchronous comparator output; edge_evt is a one-cycle pulse.
module swipt_sync_filter
    import swipt_pkg::*;
#(
    parameter int GLITCH_CYC = DEF_GLITCH_CYC
) (
    input  logic clk,
    input  logic nrst,
    input  logic din,
    output logic edge_evt
);

    localparam logic [3:0] G_LAST = 4'(GLITCH_CYC);

    logic       sync1;
    logic       sync2;
    logic       filt;
    logic       filt_d;
    logic [3:0] gcnt;
    logic [3:0] gcnt_inc;

    assign gcnt_inc = gcnt + 4'd1;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            filt     <= 1'b0;
            filt_d   <= 1'b0;
            gcnt     <= 4'd0;
            edge_evt <= 1'b0;
        end else begin
            sync1    <= din;
            sync2    <= sync1;
            filt_d   <= filt;
            edge_evt <= filt & ~filt_d;
            // Any sample that agrees with the filtered level restarts the run.
            if (sync2 != filt) begin
                if (gcnt_inc == G_LAST) begin
                    filt <= sync2;
                    gcnt <= 4'd0;
                end else begin
                    gcnt <= gcnt_inc;
                end
            end else begin
                gcnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/swipt_period_meter.sv
// Measures the period of the sliced ADC waveform in clk cycles, averages
// 2^AVG_LG periods and reports lock/timeout status.
//
// state   | meaning
// IDLE    | swiptAlive low; counters cleared
// ARM     | waiting for the first rising edge; timeout still counted
// MEASURE | counting cycles between edges and accumulating periods
module swipt_period_meter
    import swipt_pkg::*;
#(
    parameter int          PERIOD_W   = DEF_PERIOD_W,
    parameter int          AVG_LG     = DEF_AVG_LG,
    parameter int          GLITCH_CYC = DEF_GLITCH_CYC,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 nrst,
    swipt_period_meter_if.slave  bus
);

    localparam int                  ACC_W  = PERIOD_W + AVG_LG;
    localparam logic [PERIOD_W-1:0] TO_CNT = PERIOD_W'(TIMEOUT);
    localparam logic [AVG_LG-1:0]   N_LAST = '1;

    logic edge_evt;

    state_t              state_q,   state_d;
    logic [PERIOD_W-1:0] cnt_q,     cnt_d;
    logic [ACC_W-1:0]    acc_q,     acc_d;
    logic [AVG_LG-1:0]   n_q,       n_d;
    logic [PERIOD_W-1:0] avg_q,     avg_d;
    logic                valid_q,   valid_d;
    logic                locked_q,  locked_d;
    logic                timeout_q, timeout_d;

    logic [PERIOD_W-1:0] cnt_sat;
    logic [ACC_W-1:0]    acc_sum;

    swipt_sync_filter #(
        .GLITCH_CYC (GLITCH_CYC)
    ) u_sync_filter (
        .clk      (clk),
        .nrst     (nrst),
        .din      (bus.ADC_comp),
        .edge_evt (edge_evt)
    );

    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_W'(1);
    assign acc_sum = acc_q + ACC_W'(cnt_q);

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            avg_q     <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            avg_q     <= avg_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        n_d       = n_q;
        avg_d     = avg_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        // Losing swiptAlive overrides everything, including a coincident edge.
        if (!bus.swiptAlive) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            acc_d     = '0;
            n_d       = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    n_d     = '0;
                    state_d = ST_ARM;
                end

                ST_ARM: begin
                    if (edge_evt) begin
                        cnt_d   = PERIOD_W'(1);
                        acc_d   = '0;
                        n_d     = '0;
                        state_d = ST_MEASURE;
                    end else begin
                        cnt_d = cnt_sat;
                        if (cnt_q == TO_CNT) begin
                            timeout_d = 1'b1;
                        end
                    end
                end

                ST_MEASURE: begin
                    // cnt holds the full period here, so an edge wins over timeout.
                    if (edge_evt) begin
                        cnt_d = PERIOD_W'(1);
                        if (n_q == N_LAST) begin
                            avg_d     = PERIOD_W'(acc_sum >> AVG_LG);
                            valid_d   = 1'b1;
                            locked_d  = 1'b1;
                            timeout_d = 1'b0;
                            acc_d     = '0;
                            n_d       = '0;
                        end else begin
                            acc_d = acc_sum;
                            n_d   = n_q + AVG_LG'(1);
                        end
                    end else if (cnt_q == TO_CNT) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        cnt_d     = '0;
                        acc_d     = '0;
                        n_d       = '0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.period_avg   = avg_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_swipt_period_meter.sv
// Scoreboard bench for swipt_period_meter: stimulus pushes expected averages,
// a negedge monitor pops and checks them whenever period_valid pulses.
module tb_swipt_period_meter;

    localparam int TB_TO = 1000;

    logic clk  = 1'b0;
    logic nrst = 1'b1;

    int cyc       = 0;
    int total     = 0;
    int bad       = 0;
    int nv        = 0;
    int last_rise = 0;
    int vc [2];
    int exp_q [$];

    swipt_period_meter_if #(.PERIOD_W(16)) bus ();

    swipt_period_meter #(
        .TIMEOUT (TB_TO)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Each call starts on a negedge and lasts exactly hi+lo cycles.
    task automatic wave(input int hi, input int lo);
        bus.ADC_comp = 1'b1;
        last_rise = cyc;
        repeat (hi) @(negedge clk);
        bus.ADC_comp = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic glitch_wave();
        bus.ADC_comp = 1'b1;
        last_rise = cyc;
        repeat (50) @(negedge clk);
        bus.ADC_comp = 1'b0;
        repeat (20) @(negedge clk);
        bus.ADC_comp = 1'b1;
        @(negedge clk);
        bus.ADC_comp = 1'b0;
        repeat (29) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        int e;
        if (!nrst && bus.period_valid) begin
            if (nv < 2) vc[nv] = cyc;
            nv++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("period_avg", int'(bus.period_avg), e);
                check("locked_at_valid", int'(bus.locked), 1);
                check("timeout_at_valid", int'(bus.timeout), 0);
            end
        end
    end

    initial begin
        int waited;
        bus.swiptAlive = 1'b0;
        bus.ADC_comp   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period_avg", int'(bus.period_avg), 0);
        check("rst_valid", int'(bus.period_valid), 0);
        check("rst_locked", int'(bus.locked), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        bus.swiptAlive = 1'b1;
        repeat (5) @(negedge clk);

        // Plain 100-cycle square wave: two averages.
        exp_q.push_back(100);
        exp_q.push_back(100);
        repeat (16) wave(50, 50);

        // Alternating 99/101.
        exp_q.push_back(100);
        repeat (4) begin
            wave(50, 49);
            wave(50, 51);
        end
        check("valid_count_s1", nv, 2);
        check("valid_spacing", vc[1] - vc[0], 800);

        // 7x100 + 107 = 807, truncated to 100.
        exp_q.push_back(100);
        repeat (7) wave(50, 50);
        wave(50, 57);

        // One-cycle glitches in the low phase must be filtered out.
        exp_q.push_back(100);
        repeat (8) glitch_wave();

        // Final rising edge, then silence until timeout.
        wave(50, 0);
        waited = 0;
        while (!bus.timeout && waited < TB_TO + 50) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_seen", int'(bus.timeout), 1);
        check("timeout_delay", cyc - last_rise, TB_TO + 6);
        check("locked_after_to", int'(bus.locked), 0);
        check("avg_hold_after_to", int'(bus.period_avg), 100);

        // Resume toggling: relock after 8 periods.
        exp_q.push_back(100);
        repeat (9) wave(50, 50);

        // Drop swiptAlive after four 60-cycle edges; partial average discarded.
        repeat (4) wave(30, 30);
        bus.swiptAlive = 1'b0;
        repeat (20) @(negedge clk);
        check("drop_locked", int'(bus.locked), 0);
        check("drop_timeout", int'(bus.timeout), 0);
        check("drop_avg_hold", int'(bus.period_avg), 100);
        bus.swiptAlive = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back(100);
        repeat (9) wave(50, 50);

        // Asynchronous reset mid-measurement, away from any clock edge.
        repeat (3) wave(50, 50);
        bus.ADC_comp = 1'b1;
        repeat (10) @(negedge clk);
        #3 nrst = 1'b1;
        #1;
        check("async_rst_avg", int'(bus.period_avg), 0);
        check("async_rst_valid", int'(bus.period_valid), 0);
        check("async_rst_locked", int'(bus.locked), 0);
        check("async_rst_timeout", int'(bus.timeout), 0);
        @(negedge clk);
        bus.ADC_comp = 1'b0;
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        repeat (3) @(negedge clk);

        exp_q.push_back(80);
        repeat (9) wave(40, 40);

        waited = 0;
        while (exp_q.size() != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("results_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
